// File: rtl/mult_sched_if.sv
// Client and multiplier-side signal bundle for mult_sched.
// The scheduler takes the master side; the clients and multiplier take the slave side.
interface mult_sched_if #(
    parameter int SIZE = 4
);
    logic [1:0]        req;
    logic [SIZE-1:0]   a0;
    logic [SIZE-1:0]   b0;
    logic [SIZE-1:0]   a1;
    logic [SIZE-1:0]   b1;
    logic [1:0]        grant;
    logic [1:0]        done;
    logic [2*SIZE-1:0] result;
    logic              busy;
    logic              err;
    logic [SIZE-1:0]   mul_A;
    logic [SIZE-1:0]   mul_B;
    logic              mul_start;
    logic [SIZE-1:0]   mul_HM;
    logic [SIZE-1:0]   mul_LM;
    logic              mul_fin;

    modport master (
        input  req, a0, b0, a1, b1, mul_HM, mul_LM, mul_fin,
        output grant, done, result, busy, err, mul_A, mul_B, mul_start
    );

    modport slave (
        output req, a0, b0, a1, b1, mul_HM, mul_LM, mul_fin,
        input  grant, done, result, busy, err, mul_A, mul_B, mul_start
    );
endinterface

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one iterative shift-add multiplier between two clients,
// with a run-phase watchdog that forces a zero result and a sticky error.
//
// state | meaning
// IDLE  | arbitrate pending requests, latch winner's operands
// LOAD  | multiplier loads B and presets its counter; arm watchdog
// RUN   | multiplier shifts; wait for fin or watchdog terminal count
// DONE  | one-cycle done pulse to the served client
module mult_sched #(
    parameter int SIZE = 4,
    parameter int TMO  = SIZE + 2
) (
    input  logic          clk,
    input  logic          reset,
    mult_sched_if.master  bus
);
    localparam int WW = (TMO > 1) ? $clog2(TMO) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t            state, nxt_state;
    logic              prio, nxt_prio;
    logic [1:0]        grant, nxt_grant;
    logic [SIZE-1:0]   op_a, nxt_op_a;
    logic [SIZE-1:0]   op_b, nxt_op_b;
    logic [2*SIZE-1:0] result, nxt_result;
    logic              err, nxt_err;
    logic [WW-1:0]     wd, nxt_wd;
    logic              win;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            prio   <= 1'b0;
            grant  <= 2'b00;
            op_a   <= '0;
            op_b   <= '0;
            result <= '0;
            err    <= 1'b0;
            wd     <= '0;
        end else begin
            state  <= nxt_state;
            prio   <= nxt_prio;
            grant  <= nxt_grant;
            op_a   <= nxt_op_a;
            op_b   <= nxt_op_b;
            result <= nxt_result;
            err    <= nxt_err;
            wd     <= nxt_wd;
        end
    end

    always_comb begin
        nxt_state  = state;
        nxt_prio   = prio;
        nxt_grant  = grant;
        nxt_op_a   = op_a;
        nxt_op_b   = op_b;
        nxt_result = result;
        nxt_err    = err;
        nxt_wd     = wd;
        win        = 1'b0;
        case (state)
            IDLE: begin
                nxt_grant = 2'b00;
                if (|bus.req) begin
                    // Contention goes to the pointer; a lone requester always wins.
                    win       = (bus.req == 2'b11) ? prio : bus.req[1];
                    nxt_grant = win ? 2'b10 : 2'b01;
                    nxt_op_a  = win ? bus.a1 : bus.a0;
                    nxt_op_b  = win ? bus.b1 : bus.b0;
                    nxt_prio  = ~win;
                    nxt_state = LOAD;
                end
            end
            LOAD: begin
                nxt_wd    = WW'(TMO - 1);
                nxt_state = RUN;
            end
            RUN: begin
                if (bus.mul_fin) begin
                    nxt_result = {bus.mul_HM, bus.mul_LM};
                    nxt_state  = DONE;
                end else if (wd == '0) begin
                    nxt_err    = 1'b1;
                    nxt_result = '0;
                    nxt_state  = DONE;
                end else begin
                    nxt_wd = wd - 1'b1;
                end
            end
            DONE: begin
                nxt_grant = 2'b00;
                nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    assign bus.grant     = grant;
    assign bus.done      = (state == DONE) ? grant : 2'b00;
    assign bus.result    = result;
    assign bus.busy      = (state != IDLE);
    assign bus.err       = err;
    assign bus.mul_A     = op_a;
    assign bus.mul_B     = op_b;
    assign bus.mul_start = (state == RUN);
endmodule

// File: tb/tb_mult_sched.sv
// Randomized bench for mult_sched with a behavioural shift-add multiplier and a
// job-level reference model (arbitration pointer, products, latency, sticky error).
module tb_mult_sched;
    localparam int SIZE = 4;
    localparam int TMO  = SIZE + 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mult_sched_if #(.SIZE(SIZE)) bus ();

    mult_sched #(.SIZE(SIZE), .TMO(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // behavioural itmult: load when start=0, SIZE shift-add steps when start=1
    logic [2*SIZE-1:0] acc;
    int                cnt;
    bit                fin_kill = 1'b0;

    function automatic logic [2*SIZE-1:0] mstep(input logic [2*SIZE-1:0] v, input logic [SIZE-1:0] a);
        logic [SIZE:0] s;
        s = {1'b0, v[2*SIZE-1:SIZE]} + (v[0] ? {1'b0, a} : '0);
        return {s, v[SIZE-1:1]};
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            acc <= '0;
            cnt <= 0;
        end else if (!bus.mul_start) begin
            acc <= {{SIZE{1'b0}}, bus.mul_B};
            cnt <= SIZE;
        end else if (cnt > 0) begin
            acc <= mstep(acc, bus.mul_A);
            cnt <= cnt - 1;
        end
    end

    assign bus.mul_HM  = acc[2*SIZE-1:SIZE];
    assign bus.mul_LM  = acc[SIZE-1:0];
    assign bus.mul_fin = (cnt == 0) && !fin_kill;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // reference model state
    bit              pend [2];
    logic [SIZE-1:0] ma [2];
    logic [SIZE-1:0] mb [2];
    bit              mprio;
    bit              m_err;

    task automatic model_clear();
        pend[0] = 0; pend[1] = 0;
        mprio = 0; m_err = 0;
    endtask

    task automatic set_req(input int i, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        bus.req[i] = 1'b1;
        if (i == 0) begin bus.a0 = a; bus.b0 = b; end
        else        begin bus.a1 = a; bus.b1 = b; end
        pend[i] = 1; ma[i] = a; mb[i] = b;
    endtask

    task automatic do_reset();
        bus.req = 2'b00;
        reset = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", bus.grant, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.err, 0);
        check("rst_start", bus.mul_start, 0);
        check("rst_mul_A", bus.mul_A, 0);
        check("rst_mul_B", bus.mul_B, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge with the DUT in IDLE and requests already raised.
    task automatic serve(input bit perturb);
        int win, exp_res, exp_lat, lat;
        bit seen;
        if (pend[0] && pend[1]) win = int'(mprio);
        else win = pend[1] ? 1 : 0;
        mprio = (win == 0);
        if (fin_kill) begin
            exp_res = 0; m_err = 1; exp_lat = TMO + 1;
        end else begin
            exp_res = int'(ma[win]) * int'(mb[win]); exp_lat = SIZE + 2;
        end
        @(posedge clk); #1;
        check("grant", bus.grant, (win == 1) ? 2 : 1);
        check("mul_A", bus.mul_A, ma[win]);
        check("mul_B", bus.mul_B, mb[win]);
        lat = 0; seen = 0;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (perturb && lat == 2) begin
                if (win == 1) begin bus.a1 = ~ma[1]; bus.b1 = ~mb[1]; end
                else          begin bus.a0 = ~ma[0]; bus.b0 = ~mb[0]; end
            end
            if (perturb && lat == 3) begin
                check("hold_A", bus.mul_A, ma[win]);
                check("hold_B", bus.mul_B, mb[win]);
            end
            if (bus.done != 2'b00) seen = 1;
        end
        check("done_seen", seen, 1);
        check("latency", lat, exp_lat);
        check("done", bus.done, (win == 1) ? 2 : 1);
        check("result", bus.result, exp_res);
        check("err", bus.err, m_err);
        check("grant_at_done", bus.grant, (win == 1) ? 2 : 1);
        bus.req[win] = 1'b0;
        pend[win] = 0;
        @(posedge clk); #1;
        check("done_one_cycle", bus.done, 0);
        check("idle_busy", bus.busy, 0);
        check("idle_grant", bus.grant, 0);
        check("result_hold", bus.result, exp_res);
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bus.req = 2'b00;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        model_clear();
        @(negedge clk);
        do_reset();

        // simultaneous after reset: client 0 first, then the held client 1
        set_req(0, 4'd15, 4'd15);
        set_req(1, 4'd7, 4'd3);
        serve(0);
        serve(0);
        // zero operand on client 1
        set_req(1, 4'd0, 4'd9);
        serve(0);
        // single request on client 0
        set_req(0, 4'd13, 4'd11);
        serve(0);
        // operand stability
        set_req(0, 4'd9, 4'd14);
        serve(1);

        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < 2; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    set_req(i, SIZE'($urandom_range(0, 15)), SIZE'($urandom_range(0, 15)));
            if (!pend[0] && !pend[1])
                set_req(int'($urandom_range(0, 1)), SIZE'($urandom_range(0, 15)), SIZE'($urandom_range(0, 15)));
            serve($urandom_range(0, 3) == 0);
        end
        while (pend[0] || pend[1]) serve(0);

        // timeout, then a good job with err still sticky
        fin_kill = 1'b1;
        set_req(1, 4'd5, 4'd6);
        serve(0);
        fin_kill = 1'b0;
        set_req(0, 4'd12, 4'd10);
        serve(0);

        // reset during the 3rd RUN cycle
        set_req(0, 4'd11, 4'd7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus.req = 2'b00;
        model_clear();
        @(posedge clk); #1;
        check("midrst_grant", bus.grant, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_result", bus.result, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_err", bus.err, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("midrst_no_done", bus.done, 0);
        end
        @(negedge clk);
        // pointer back to 0 after reset
        set_req(1, 4'd3, 4'd4);
        set_req(0, 4'd2, 4'd8);
        serve(0);
        serve(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mult_sched.md
# mult_sched

Two-requester round-robin scheduler that shares one iterative shift-add multiplier (`itmult`, SIZE-cycle) between two clients. It sits between the requesters and the multiplier. It latches the granted client's operands and sequences the multiplier's load and run phases. It captures the 2·SIZE-bit product and returns it with a one-cycle done pulse. A watchdog flags a multiplier that never raises `fin`.

## Interface
- `SIZE`, default 4: operand width; the multiplier runs SIZE shift steps.
- `TMO`, default SIZE+2: maximum RUN cycles before timeout.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on posedge.
- `reset`: input, 1 bit. Synchronous, active-low; sampled on posedge `clk`.
- `req`: input, 2 bits. `req[i]` means client i requests a multiply. It is held until `done[i]`.
- `a0`, `b0`: input, SIZE bits each. Client 0 operands; stable while `req[0]` is high.
- `a1`, `b1`: input, SIZE bits each. Client 1 operands; stable while `req[1]` is high.
- `grant`: output, 2 bits. One-hot; high from LOAD through DONE for the served client.
- `done`: output, 2 bits. One-cycle pulse to the served client, in the DONE state.
- `result`: output, 2·SIZE bits. Registered product; valid while `done` is high and held until the next capture.
- `busy`: output, 1 bit. High in any state other than IDLE.
- `err`: output, 1 bit. Sticky timeout flag; cleared only by reset.
- `mul_A`, `mul_B`: output, SIZE bits each. Operands to the multiplier, taken from the latched copy.
- `mul_start`: output, 1 bit. Multiplier start level: 0 means load/hold, 1 means shift.
- `mul_HM`, `mul_LM`: input, SIZE bits each. Multiplier product halves.
- `mul_fin`: input, 1 bit. Multiplier completion flag.

## Operation
- **States:** IDLE, LOAD, RUN, DONE. The state register is 2 bits.
- **IDLE:**
  - `mul_start`=0.
  - If any `req` is high: pick a winner, latch its operands into opA/opB, set `grant`, and go to LOAD.
  - Otherwise stay in IDLE.
- **Arbitration:**
  - A 1-bit pointer `prio` selects the preferred client.
  - If only one `req` is high, that client wins.
  - If both are high, client `prio` wins.
  - After each grant, `prio` becomes the complement of the winner.
  - The grant decision is made only in IDLE; a request that arrives later waits.
- **LOAD** (exactly 1 cycle):
  - `mul_start`=0, so the multiplier loads B and presets its counter on this edge.
  - Clear the watchdog counter and go to RUN.
- **RUN:**
  - `mul_start`=1 and the watchdog increments every cycle.
  - If `mul_fin`=1: capture `{mul_HM,mul_LM}` into `result` and go to DONE.
  - Else if the watchdog equals TMO−1: set `err`, load `result`=0, and go to DONE.
  - `mul_fin` is ignored in every state except RUN, because it is high after multiplier reset.
- **DONE** (exactly 1 cycle):
  - `done[winner]`=1, `mul_start`=0, `grant` is still held.
  - Go to IDLE; `grant` clears on entry to IDLE.
  - `req` is not sampled in DONE. The client drops `req` after `done`; if it keeps `req` high, that is a new job, arbitrated in IDLE.
- **Width rules:**
  - `result` = A·B, unsigned, full 2·SIZE bits, no truncation.
  - `mul_A`/`mul_B` are driven from the latched opA/opB, never from the live client inputs.
- **Reset** (`reset`=0 at a posedge) applies in any state, including mid-RUN. The partial product is discarded and no `done` is issued for the aborted job. Registers after reset:
  - state=IDLE, `prio`=0
  - `grant`=00, `done`=00, `result`=0, `err`=0, `busy`=0
  - `mul_start`=0, opA=opB=0

## Timing
- Edge k: IDLE samples `req`. After k, the design is in LOAD with `grant` high.
- Edge k+1: the multiplier loads; the design enters RUN.
- Edges k+2 … k+1+SIZE: SIZE multiplier shifts. `mul_fin` rises after edge k+1+SIZE.
- Edge k+2+SIZE: the product is captured and the design enters DONE.
  - This is one extra multiplier shift, which is harmless because the capture uses the pre-edge value.
- Edge k+3+SIZE: the design returns to IDLE.
- Request to `done` is SIZE+2 edges. Back-to-back throughput is one job per SIZE+4 cycles.
- Worst-case wait for a losing requester is one full job (SIZE+4 cycles) plus one IDLE cycle.

## Test plan
- **Single request, SIZE=4:**
  - Stimulus: `req`=01, a0=13, b0=11.
  - Required: `grant`=01 one cycle later; `done[0]` exactly 6 edges after sampling; `result`=143 (8'h8F); `err`=0.
- **Simultaneous requests:**
  - Stimulus: `req`=11 after reset, a0=15, b0=15, a1=7, b1=3.
  - Required: client 0 is served first with `result`=225. Then, with `req[1]` still high, client 1 is served with `result`=21. `prio` toggles each time.
- **Zero operand:**
  - Stimulus: a1=0, b1=9.
  - Required: `result`=0, `done[1]` pulse, `err`=0.
- **Reset mid-RUN:**
  - Stimulus: assert `reset`=0 in the 3rd RUN cycle.
  - Required: next cycle state=IDLE; `grant`, `done`, `result`, `busy` are all 0; no `done` pulse.
- **Timeout:**
  - Stimulus: tie `mul_fin`=0.
  - Required: after TMO RUN cycles, `err`=1, `result`=0, `done` pulses. `err` stays 1 through later good jobs until reset.
- **Operand stability:**
  - Stimulus: change a0/b0 during RUN.
  - Required: `mul_A`/`mul_B` are unchanged; `result` matches the operands latched at grant time.
